// File: rtl/seg7_pkg.sv
// Shared types and segment lookup for the two-digit 7-segment receive path.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Index = digit value; bit6..0 = g..a, active-high.
    localparam seg7_t SEG7_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam seg7_t SEG7_BLANK = 7'h00;

    typedef struct packed {
        logic [3:0] bcd;
        logic       bad;
    } digit_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Single-digit 7-segment pattern to BCD lookup with bad-pattern flag.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  seg7_t  seg,
    input  logic   allow_blank,
    output digit_t dig
);

    always_comb begin
        dig.bcd = '0;
        dig.bad = 1'b1;
        // A blanked leading digit reads as zero; a blank ones digit stays bad.
        if (allow_blank && seg == SEG7_BLANK)
            dig.bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG7_LUT[i]) begin
                dig.bcd = 4'(i);
                dig.bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Two-stage decode/combine of a tens/ones segment pair into a binary value.
// Define SEG7_ERR_EN to add m_err and forward bad beats instead of dropping them.
module seg7_pair_decoder
    import seg7_pkg::*;
#(
    parameter int W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0][6:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data
`ifdef SEG7_ERR_EN
    ,
    output logic             m_err
`endif
);

    localparam longint MAXV = (longint'(1) << W) - 1;

    logic [2:1]   vld_pipe;
    digit_t [1:0] dig_d, dig_q;
    logic         rdy1, rdy2;
    logic         bad1, ovf, keep;
    logic [6:0]   sum;
    logic [W-1:0] data_d;

    for (genvar i = 0; i < 2; i++) begin : g_dec
        seg7_digit_dec u_dec (
            .seg         (s_data[i]),
            .allow_blank (i == 1),
            .dig         (dig_d[i])
        );
    end

    // Ready ripples back combinationally so a full pipe still moves one beat per clk.
    assign rdy2    = !vld_pipe[2] || m_ready;
    assign rdy1    = !vld_pipe[1] || rdy2;
    assign s_ready = rdy1;
    assign m_valid = vld_pipe[2];

    always_comb begin
        bad1   = dig_q[1].bad | dig_q[0].bad;
        sum    = 7'(dig_q[1].bcd) * 7'd10 + 7'(dig_q[0].bcd);
        ovf    = longint'(sum) > MAXV;
        data_d = W'(sum);
        if (bad1)
            data_d = '0;
        else if (ovf)
            data_d = '1;
    end

`ifdef SEG7_ERR_EN
    assign keep = 1'b1;
    logic err_q;
    assign m_err = err_q;
`else
    // Without an error port, bad beats are silently dropped here.
    assign keep = !bad1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            dig_q    <= '0;
            m_data   <= '0;
`ifdef SEG7_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (rdy1) begin
                vld_pipe[1] <= s_valid;
                if (s_valid)
                    dig_q <= dig_d;
            end
            if (rdy2) begin
                vld_pipe[2] <= vld_pipe[1] && keep;
                if (vld_pipe[1] && keep) begin
                    m_data <= data_d;
`ifdef SEG7_ERR_EN
                    err_q  <= bad1 || ovf;
`endif
                end
            end
        end
    end

endmodule
